// File: rtl/note_sequencer.sv
// Melody sequencer: walks a table of {half_period, duration} notes and drives
// a square-wave tone generator, inserting a silent gap after each note.
module note_sequencer #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int TICK_DIV  = 50000,
  parameter int GAP_TICKS = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [20:0]   cfg_half_period,
  input  logic [11:0]   cfg_dur,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [AW-1:0] last_idx,
  input  logic [15:0]   master_volume,
  output logic [20:0]   half_period,
  output logic [15:0]   volume,
  output logic          enable,
  output logic          busy,
  output logic [AW-1:0] note_idx,
  output logic          done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic HAS_GAP = (GAP_TICKS != 0);

  typedef enum logic [2:0] {IDLE, FETCH, NOTE, GAP, DONE} state_t;

  state_t        state;
  logic [32:0]   tbl [DEPTH];
  logic [32:0]   entry;
  logic [20:0]   entry_hp;
  logic [11:0]   entry_dur;
  logic [20:0]   hp_r;
  logic [11:0]   dur_cnt;
  logic [15:0]   gap_cnt;
  logic [PW-1:0] presc;
  logic          tick;
  state_t        adv_state;
  logic [AW-1:0] adv_idx;

  // The table survives reset so a melody programmed once can be replayed.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      tbl[cfg_addr] <= {cfg_half_period, cfg_dur};
    end
  end

  assign entry     = tbl[note_idx];
  assign entry_hp  = entry[32:12];
  assign entry_dur = entry[11:0];
  assign tick      = (presc == PW'(TICK_DIV - 1));

  // Where to go once the current note (and its gap) has finished.
  always_comb begin
    adv_state = DONE;
    adv_idx   = note_idx;
    if (note_idx != last_idx) begin
      adv_state = FETCH;
      adv_idx   = note_idx + 1'b1;
    end else if (loop) begin
      adv_state = FETCH;
      adv_idx   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || stop) begin
      state       <= IDLE;
      hp_r        <= '0;
      dur_cnt     <= '0;
      gap_cnt     <= '0;
      presc       <= '0;
      half_period <= '0;
      volume      <= '0;
      enable      <= 1'b0;
      busy        <= 1'b0;
      note_idx    <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            note_idx <= '0;
            busy     <= 1'b1;
          end
        end

        FETCH: begin
          hp_r        <= entry_hp;
          dur_cnt     <= (entry_dur == 12'd0) ? 12'd1 : entry_dur;
          presc       <= '0;
          state       <= NOTE;
          enable      <= (entry_hp != 21'd0);
          half_period <= entry_hp;
          volume      <= master_volume;
        end

        NOTE: begin
          enable      <= (hp_r != 21'd0);
          half_period <= hp_r;
          volume      <= master_volume;
          if (tick) begin
            presc   <= '0;
            dur_cnt <= dur_cnt - 12'd1;
            if (dur_cnt == 12'd1) begin
              enable      <= 1'b0;
              half_period <= '0;
              volume      <= '0;
              if (HAS_GAP) begin
                state   <= GAP;
                gap_cnt <= 16'(GAP_TICKS);
              end else begin
                state    <= adv_state;
                note_idx <= adv_idx;
                done     <= (adv_state == DONE);
              end
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end

        GAP: begin
          if (tick) begin
            presc   <= '0;
            gap_cnt <= gap_cnt - 16'd1;
            if (gap_cnt == 16'd1) begin
              state    <= adv_state;
              note_idx <= adv_idx;
              done     <= (adv_state == DONE);
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Randomised and directed bench for note_sequencer, checked every cycle against
// a timeline model (queue of upcoming output cycles) built from the note table.
module tb_note_sequencer;

  localparam int TD = 4;
  localparam int GT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [20:0] cfg_half_period = '0;
  logic [11:0] cfg_dur = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [3:0]  last_idx = '0;
  logic [15:0] master_volume = '0;
  logic [20:0] half_period;
  logic [15:0] volume;
  logic        enable;
  logic        busy;
  logic [3:0]  note_idx;
  logic        done;

  note_sequencer #(.DEPTH(16), .AW(4), .TICK_DIV(TD), .GAP_TICKS(GT)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_half_period(cfg_half_period), .cfg_dur(cfg_dur), .start(start),
    .stop(stop), .loop(loop), .last_idx(last_idx), .master_volume(master_volume),
    .half_period(half_period), .volume(volume), .enable(enable), .busy(busy),
    .note_idx(note_idx), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Timeline model: each accepted note expands into a list of output cycles.
  typedef struct { logic note; logic [20:0] hp; } seg_t;
  localparam int P_IDLE = 0, P_FETCH = 1, P_ADV = 2, P_DONE = 3;

  seg_t        segq[$];
  seg_t        s;
  int          ph = P_IDLE;
  int          dticks;
  logic [3:0]  cur = '0;
  logic [20:0] m_hp [16];
  logic [11:0] m_dur [16];
  logic        model_valid = 1'b0;
  logic        e_en, e_busy, e_done;
  logic [20:0] e_hp;
  logic [15:0] e_vol;
  logic [3:0]  e_idx;

  always @(posedge clk) begin
    e_en = 1'b0; e_hp = '0; e_vol = '0; e_busy = 1'b0; e_done = 1'b0;
    if (!rst_n || stop) begin
      segq.delete();
      ph = P_IDLE;
      cur = '0;
      model_valid = 1'b1;
    end else begin
      if (segq.size() == 0) begin
        case (ph)
          P_IDLE: if (start) begin ph = P_FETCH; cur = '0; end
          P_FETCH: begin
            dticks = (m_dur[cur] == 12'd0) ? 1 : int'(m_dur[cur]);
            for (int k = 0; k < dticks * TD; k++) segq.push_back('{1'b1, m_hp[cur]});
            for (int k = 0; k < GT * TD; k++) segq.push_back('{1'b0, 21'd0});
            ph = P_ADV;
          end
          P_ADV: begin
            if (cur != last_idx) begin cur = cur + 4'd1; ph = P_FETCH; end
            else if (loop) begin cur = '0; ph = P_FETCH; end
            else ph = P_DONE;
          end
          default: ph = P_IDLE;
        endcase
      end
      if (segq.size() > 0) begin
        s = segq.pop_front();
        e_busy = 1'b1;
        if (s.note) begin
          e_en = (s.hp != 21'd0);
          e_hp = s.hp;
          e_vol = master_volume;
        end
      end else if (ph == P_FETCH) begin
        e_busy = 1'b1;
      end else if (ph == P_DONE) begin
        e_busy = 1'b1;
        e_done = 1'b1;
      end
    end
    e_idx = cur;
    if (cfg_we) begin
      m_hp[cfg_addr] = cfg_half_period;
      m_dur[cfg_addr] = cfg_dur;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check_output("enable", 32'(enable), 32'(e_en));
      check_output("half_period", 32'(half_period), 32'(e_hp));
      check_output("volume", 32'(volume), 32'(e_vol));
      check_output("busy", 32'(busy), 32'(e_busy));
      check_output("note_idx", 32'(note_idx), 32'(e_idx));
      check_output("done", 32'(done), 32'(e_done));
    end
  end

  logic        tr_en [64];
  logic        tr_busy [64];
  logic        tr_done [64];
  logic [20:0] tr_hp [64];
  logic [15:0] tr_vol [64];
  logic [3:0]  tr_idx [64];

  task automatic write_entry(input logic [3:0] a, input logic [20:0] hp, input logic [11:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_half_period = hp; cfg_dur = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic apply_stimulus_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records n cycles starting with the current one; optionally re-pulses start.
  task automatic run_trace(input int n, input int extra_start_at);
    for (int i = 0; i < n; i++) begin
      tr_en[i] = enable; tr_busy[i] = busy; tr_done[i] = done;
      tr_hp[i] = half_period; tr_vol[i] = volume; tr_idx[i] = note_idx;
      start = (i == extra_start_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    check_output("idle_timeout", 32'(busy), 32'd0);
  endtask

  function automatic int sum_en(input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i <= hi; i++) c += int'(tr_en[i]);
    return c;
  endfunction

  function automatic int sum_done(input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i <= hi; i++) c += int'(tr_done[i]);
    return c;
  endfunction

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_enable", 32'(enable), 32'd0);
    check_output("rst_hp", 32'(half_period), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) write_entry(4'(a), 21'(a * 3 + 1), 12'(a % 3 + 1));

    // Two-note melody, no loop.
    write_entry(4'd0, 21'd10, 12'd2);
    write_entry(4'd1, 21'd20, 12'd1);
    last_idx = 4'd1; loop = 1'b0; master_volume = 16'h1000;
    apply_stimulus_start();
    run_trace(24, -1);
    for (int i = 0; i < 24; i++)
      check_output("t1_en_trace", 32'(tr_en[i]), 32'((i >= 1 && i <= 8) || (i >= 14 && i <= 17)));
    check_output("t1_hp_e0", 32'(tr_hp[1]), 32'd10);
    check_output("t1_hp_e1", 32'(tr_hp[14]), 32'd20);
    check_output("t1_vol", 32'(tr_vol[1]), 32'h1000);
    check_output("t1_done_at", 32'(tr_done[22]), 32'd1);
    check_output("t1_done_count", 32'(sum_done(0, 23)), 32'd1);
    check_output("t1_busy_done", 32'(tr_busy[22]), 32'd1);
    check_output("t1_busy_after", 32'(tr_busy[23]), 32'd0);

    // Rest note stays silent but busy.
    write_entry(4'd0, 21'd0, 12'd3);
    last_idx = 4'd0;
    apply_stimulus_start();
    run_trace(20, -1);
    check_output("t2_en_sum", 32'(sum_en(0, 19)), 32'd0);
    check_output("t2_busy", 32'(tr_busy[6]), 32'd1);
    check_output("t2_idx", 32'(tr_idx[6]), 32'd0);
    check_output("t2_done_at", 32'(tr_done[17]), 32'd1);

    // Looping wraps back to entry 0 with no done, then stop.
    write_entry(4'd0, 21'd10, 12'd2);
    last_idx = 4'd1; loop = 1'b1;
    apply_stimulus_start();
    run_trace(30, -1);
    check_output("t3_idx_e1", 32'(tr_idx[21]), 32'd1);
    check_output("t3_idx_wrap", 32'(tr_idx[22]), 32'd0);
    check_output("t3_en_again", 32'(tr_en[23]), 32'd1);
    check_output("t3_no_done", 32'(sum_done(0, 29)), 32'd0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    loop = 1'b0;
    check_output("t3_stop_busy", 32'(busy), 32'd0);
    check_output("t3_stop_en", 32'(enable), 32'd0);
    check_output("t3_stop_done", 32'(done), 32'd0);

    // Zero duration plays as one tick.
    write_entry(4'd0, 21'd7, 12'd0);
    last_idx = 4'd0;
    apply_stimulus_start();
    run_trace(10, -1);
    check_output("t4_en_sum", 32'(sum_en(0, 9)), 32'd4);
    check_output("t4_done_at", 32'(tr_done[9]), 32'd1);
    wait_idle(50);

    // Start with stop in the same cycle; then start while busy is ignored.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check_output("t5_stop_wins", 32'(busy), 32'd0);
    write_entry(4'd0, 21'd10, 12'd2);
    last_idx = 4'd1;
    apply_stimulus_start();
    run_trace(24, 5);
    check_output("t5_en_sum", 32'(sum_en(0, 23)), 32'd12);
    check_output("t5_done_at", 32'(tr_done[22]), 32'd1);
    check_output("t5_busy_after", 32'(tr_busy[23]), 32'd0);

    // Reset mid-note keeps the table; write during FETCH reads old data.
    apply_stimulus_start();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_output("t6_rst_en", 32'(enable), 32'd0);
    check_output("t6_rst_busy", 32'(busy), 32'd0);
    check_output("t6_rst_vol", 32'(volume), 32'd0);
    apply_stimulus_start();
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_half_period = 21'd99; cfg_dur = 12'd2;
    @(negedge clk);
    cfg_we = 1'b0;
    check_output("t6_old_hp", 32'(half_period), 32'd10);
    wait_idle(100);
    apply_stimulus_start();
    @(negedge clk);
    check_output("t6_new_hp", 32'(half_period), 32'd99);
    wait_idle(100);

    // Randomised playback with live config changes, stops and resets.
    for (int it = 0; it < 40; it++) begin
      last_idx = 4'($urandom_range(0, 3));
      loop = ($urandom_range(0, 3) == 0);
      master_volume = 16'($urandom);
      for (int a = 0; a < 4; a++)
        write_entry(4'(a), ($urandom_range(0, 4) == 0) ? 21'd0 : 21'($urandom_range(1, 2097151)),
                    12'($urandom_range(0, 3)));
      apply_stimulus_start();
      for (int c = 0; c < int'($urandom_range(20, 120)); c++) begin
        start = ($urandom_range(0, 15) == 0);
        stop = ($urandom_range(0, 149) == 0);
        rst_n = ($urandom_range(0, 299) != 0);
        cfg_we = ($urandom_range(0, 7) == 0);
        cfg_addr = 4'($urandom_range(0, 15));
        cfg_half_period = ($urandom_range(0, 4) == 0) ? 21'd0 : 21'($urandom_range(1, 2097151));
        cfg_dur = 12'($urandom_range(0, 3));
        if ($urandom_range(0, 31) == 0) master_volume = 16'($urandom);
        if ($urandom_range(0, 99) == 0) last_idx = 4'($urandom_range(0, 15));
        @(negedge clk);
      end
      start = 1'b0; stop = 1'b0; rst_n = 1'b1; cfg_we = 1'b0;
      if (loop) begin
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
      end
      wait_idle(1000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
